// File: rtl/melody_sequencer_pkg.sv
// Shared types and constants for the melody sequencer and the tone oscillator it feeds.
// Holds the mode type, FSM state encoding, note markers and the fixed melody tables.
package melody_sequencer_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } MODE_TYPES;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    localparam logic [7:0] NOTE_END  = 8'hFF;
    localparam logic [7:0] NOTE_REST = 8'h00;

    localparam int NUM_MELODIES = 4;
    localparam int TABLE_DEPTH  = 8;

    // Entries past the terminator are padded with NOTE_END.
    localparam logic [7:0] MELODY_TABLE [NUM_MELODIES][TABLE_DEPTH] = '{
        '{8'd40,  8'd60,  8'd80,  8'hFF,  8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'd120, 8'd0,   8'd120, 8'hFF,  8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'd200, 8'd150, 8'd100, 8'd50,  8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'hFF,  8'hFF,  8'hFF,  8'hFF,  8'hFF, 8'hFF, 8'hFF, 8'hFF}
    };

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the sound-request source and the melody sequencer.
interface melody_sequencer_if;
    import melody_sequencer_pkg::*;

    // Handshake: trigger is level-sampled and accepted only while busy=0 and
    // state=ON; busy stays high until the sequencer is back in IDLE, and done
    // pulses for one cycle when a melody finishes without being aborted.
    MODE_TYPES   state;
    logic        trigger;
    logic [1:0]  melody_sel;
    logic [7:0]  freq;
    logic        playSound;
    logic        busy;
    logic        done;

    modport master (
        output state, trigger, melody_sel,
        input  freq, playSound, busy, done
    );

    modport slave (
        input  state, trigger, melody_sel,
        output freq, playSound, busy, done
    );

endinterface

// File: rtl/melody_sequencer_rom.sv
// Combinational melody table lookup: (sel, index) -> 8-bit note entry.
module melody_rom
    import melody_sequencer_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic [1:0]       sel,
    input  logic [IDX_W-1:0] index,
    output logic [7:0]       entry
);

    always_comb begin
        entry = NOTE_END;
        if (32'(index) < TABLE_DEPTH) begin
            entry = MELODY_TABLE[sel][3'(index)];
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Turns a one-cycle sound request into a timed note sequence for the tone oscillator.
// Optional build macro MELODY_LOOP_EN: repeat the melody while trigger stays high.
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int NOTE_TICKS = 10000000,
    parameter int GAP_TICKS  = 1000000,
    parameter int MAX_NOTES  = 8
) (
    input  logic                clk,
    input  logic                nRst,
    melody_sequencer_if.slave   bus,
    output seq_state_t          fsm_dbg
);

    localparam int IW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;

    seq_state_t     fsm, fsm_nxt;
    logic [IW-1:0]  index, index_nxt;
    logic [23:0]    tick, tick_nxt;
    logic [1:0]     sel, sel_nxt;
    logic [7:0]     freq_r, freq_nxt;
    logic           play_r, play_nxt;
    logic           busy_r, busy_nxt;
    logic           done_r, done_nxt;
    logic [7:0]     entry;
    logic           loop_ok;

    melody_rom #(.IDX_W(IW)) u_rom (
        .sel   (sel),
        .index (index),
        .entry (entry)
    );

`ifdef MELODY_LOOP_EN
    assign loop_ok = bus.trigger && (bus.state == ON);
`else
    assign loop_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (nRst) begin
            fsm    <= IDLE;
            index  <= '0;
            tick   <= '0;
            sel    <= '0;
            freq_r <= '0;
            play_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            fsm    <= fsm_nxt;
            index  <= index_nxt;
            tick   <= tick_nxt;
            sel    <= sel_nxt;
            freq_r <= freq_nxt;
            play_r <= play_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
        end
    end

    always_comb begin
        fsm_nxt   = fsm;
        index_nxt = index;
        tick_nxt  = tick;
        sel_nxt   = sel;
        freq_nxt  = freq_r;
        play_nxt  = 1'b0;
        done_nxt  = 1'b0;

        case (fsm)
            IDLE: begin
                if (bus.trigger && bus.state == ON) begin
                    sel_nxt   = bus.melody_sel;
                    index_nxt = '0;
                    fsm_nxt   = LOAD;
                end
            end
            LOAD: begin
                if (entry == NOTE_END) begin
                    if (loop_ok) begin
                        index_nxt = '0;
                    end else begin
                        fsm_nxt  = DONE;
                        done_nxt = 1'b1;
                    end
                end else begin
                    fsm_nxt  = PLAY;
                    tick_nxt = '0;
                    freq_nxt = entry;
                    play_nxt = (entry != NOTE_REST);
                end
            end
            PLAY: begin
                if (tick == 24'(NOTE_TICKS - 1)) begin
                    fsm_nxt  = GAP;
                    tick_nxt = '0;
                    freq_nxt = '0;
                end else begin
                    tick_nxt = tick + 24'd1;
                end
            end
            GAP: begin
                if (tick == 24'(GAP_TICKS - 1)) begin
                    tick_nxt = '0;
                    if (index != IW'(MAX_NOTES - 1)) begin
                        index_nxt = index + IW'(1);
                        fsm_nxt   = LOAD;
                    end else if (loop_ok) begin
                        index_nxt = '0;
                        fsm_nxt   = LOAD;
                    end else begin
                        fsm_nxt  = DONE;
                        done_nxt = 1'b1;
                    end
                end else begin
                    tick_nxt = tick + 24'd1;
                end
            end
            DONE: begin
                fsm_nxt = IDLE;
            end
            default: begin
                fsm_nxt = IDLE;
            end
        endcase

        // OFF aborts any active melody silently, without a done pulse.
        if (fsm != IDLE && bus.state == OFF) begin
            fsm_nxt  = IDLE;
            freq_nxt = '0;
            play_nxt = 1'b0;
            done_nxt = 1'b0;
        end

        busy_nxt = (fsm_nxt != IDLE);
    end

    assign bus.freq      = freq_r;
    assign bus.playSound = play_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign fsm_dbg       = fsm;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with NOTE_TICKS=4, GAP_TICKS=2.
module tb_melody_sequencer;
    import melody_sequencer_pkg::*;

    localparam int NT = 4;
    localparam int GT = 2;
    localparam int MN = 8;

    logic clk = 1'b0;
    logic nRst;
    seq_state_t fsm_dbg;

    melody_sequencer_if bus();

    melody_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT), .MAX_NOTES(MN)) dut (
        .clk     (clk),
        .nRst    (nRst),
        .bus     (bus),
        .fsm_dbg (fsm_dbg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Independent copy of the melody tables.
    int mel [4][8] = '{
        '{40, 60, 80, 255, 255, 255, 255, 255},
        '{120, 0, 120, 255, 255, 255, 255, 255},
        '{200, 150, 100, 50, 255, 255, 255, 255},
        '{255, 255, 255, 255, 255, 255, 255, 255}
    };

    // Expected per-cycle outputs {freq, playSound, busy, done}.
    logic [10:0] exp_q[$];

    typedef struct {
        int sel;
        int n_strobes;
        int busy_cycles;
        int first_freq;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [10:0] pk(input int f, input bit ps, input bit b, input bit d);
        return {8'(f), ps, b, d};
    endfunction

    // Reference trace: one LOAD cycle per table slot, NT note cycles, GT gap
    // cycles, then a DONE cycle and the return to idle.
    function automatic void build_trace(input int s, input int abort_at);
        logic [10:0] t[$];
        int i = 0;
        bit fin = 0;
        t.push_back(pk(0, 0, 1, 0));
        while (!fin) begin
            if (mel[s][i] == 255) begin
                t.push_back(pk(0, 0, 1, 1));
                fin = 1;
            end else begin
                for (int j = 0; j < NT; j++)
                    t.push_back(pk(mel[s][i], (j == 0) && (mel[s][i] != 0), 1, 0));
                for (int j = 0; j < GT; j++)
                    t.push_back(pk(0, 0, 1, 0));
                if (i == MN - 1) begin
                    t.push_back(pk(0, 0, 1, 1));
                    fin = 1;
                end else begin
                    i++;
                    t.push_back(pk(0, 0, 1, 0));
                end
            end
        end
        t.push_back(pk(0, 0, 0, 0));
        if (abort_at >= 0 && abort_at < t.size() - 1) begin
            while (t.size() > abort_at + 1) void'(t.pop_back());
            t.push_back(pk(0, 0, 0, 0));
        end
        exp_q = t;
    endfunction

    task automatic run_melody(input int s, input int abort_at, input bit noise);
        int n;
        logic [10:0] e;
        build_trace(s, abort_at);
        n = exp_q.size();
        @(negedge clk);
        bus.state = ON;
        bus.trigger = 1'b1;
        bus.melody_sel = 2'(s);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("trace sel=%0d k=%0d", s, k),
                  {21'd0, bus.freq, bus.playSound, bus.busy, bus.done}, {21'd0, e});
            if (!e[1])
                check($sformatf("idle fsm sel=%0d k=%0d", s, k), 32'(fsm_dbg), 32'(IDLE));
            bus.trigger = 1'b0;
            if (noise) begin
                bus.melody_sel = 2'($urandom_range(0, 3));
`ifndef MELODY_LOOP_EN
                bus.trigger = 1'($urandom_range(0, 1));
`endif
            end
            if (k == abort_at) begin
                bus.state = OFF;
                bus.trigger = 1'b0;
            end
            if (k == n - 1) begin
                bus.trigger = 1'b0;
                bus.state = ON;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n_ps = 0, busy_n = 0, done_n = 0, first = 0;
        bit ended = 0;
        @(negedge clk);
        bus.trigger = 1'b1;
        bus.melody_sel = 2'(v.sel);
        for (int c = 0; c < 100 && !ended; c++) begin
            @(negedge clk);
            bus.trigger = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) done_n++;
            if (bus.playSound) begin
                if (n_ps == 0) first = int'(bus.freq);
                n_ps++;
            end
            if (!bus.busy) ended = 1;
        end
        check($sformatf("vec%0d ended", v.sel), 32'(ended), 32'd1);
        check($sformatf("vec%0d strobes", v.sel), n_ps, v.n_strobes);
        check($sformatf("vec%0d busy cycles", v.sel), busy_n, v.busy_cycles);
        check($sformatf("vec%0d done count", v.sel), done_n, 1);
        check($sformatf("vec%0d first freq", v.sel), first, v.first_freq);
    endtask

    task automatic check_idle(input string name);
        check(name, {21'd0, bus.freq, bus.playSound, bus.busy, bus.done}, 32'd0);
        check({name, " fsm"}, 32'(fsm_dbg), 32'(IDLE));
    endtask

`ifdef MELODY_LOOP_EN
    task automatic loop_test();
        int exp_f [3] = '{40, 60, 80};
        int n = 0;
        bit saw_done = 0;
        @(negedge clk);
        bus.state = ON;
        bus.trigger = 1'b1;
        bus.melody_sel = 2'd0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            check("loop no done", 32'(bus.done), 32'd0);
            if (bus.playSound) begin
                check($sformatf("loop freq %0d", n), 32'(bus.freq), 32'(exp_f[n % 3]));
                n++;
            end
        end
        check("loop strobes", n >= 6, 1);
        bus.trigger = 1'b0;
        for (int c = 0; c < 40 && !saw_done; c++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1;
        end
        check("loop done after release", 32'(saw_done), 32'd1);
        @(negedge clk);
        check_idle("loop idle");
    endtask
`endif

    initial begin
        vecs[0] = '{sel: 0, n_strobes: 3, busy_cycles: 23, first_freq: 40};
        vecs[1] = '{sel: 1, n_strobes: 2, busy_cycles: 23, first_freq: 120};
        vecs[2] = '{sel: 2, n_strobes: 4, busy_cycles: 30, first_freq: 200};
        vecs[3] = '{sel: 3, n_strobes: 0, busy_cycles: 2,  first_freq: 0};

        bus.state = ON;
        bus.trigger = 1'b0;
        bus.melody_sel = 2'd0;
        nRst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset state");
        nRst = 1'b0;

        // Reset held two cycles in the middle of a PLAY.
        @(negedge clk);
        bus.trigger = 1'b1;
        bus.melody_sel = 2'd0;
        repeat (3) begin
            @(negedge clk);
            bus.trigger = 1'b0;
        end
        check("mid play freq", 32'(bus.freq), 32'd40);
        nRst = 1'b1;
        @(negedge clk);
        check_idle("reset mid play");
        @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        check_idle("after reset release");

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Exact traces for every melody, quiet inputs.
        for (int s = 0; s < 4; s++) run_melody(s, -1, 1'b0);

        // OFF during the second note of melody 2, then a clean restart.
        run_melody(2, 9, 1'b0);
        run_melody(2, -1, 1'b0);

        // Trigger with OFF in IDLE is ignored.
        @(negedge clk);
        bus.state = OFF;
        bus.trigger = 1'b1;
        @(negedge clk);
        check_idle("trigger while off");
        bus.trigger = 1'b0;
        bus.state = ON;

        // Randomized melodies, retriggers and sel changes while busy, random aborts.
        for (int r = 0; r < 10; r++) begin
            int s = $urandom_range(0, 3);
            int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1;
            run_melody(s, ab, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

`ifdef MELODY_LOOP_EN
        loop_test();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of the tone oscillator: turns a one-cycle sound request into a timed sequence of notes.
- On each note start it drives the oscillator's `freq` value and a one-cycle `playSound` strobe.
- Melodies are fixed tables (up to MAX_NOTES entries each, selected by `melody_sel`).
- Gated by the same ON/OFF mode type the oscillator uses.

Parameters:
- NOTE_TICKS, 10000000, clk cycles each note is held. Matches the oscillator's play window.
- GAP_TICKS, 1000000, silent clk cycles inserted after every note.
- MAX_NOTES, 8, table depth per melody. Index width is $clog2(MAX_NOTES).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- nRst  in  1  synchronous, active-high reset (1 = reset), sampled on clk rising edge
- state  in  MODE_TYPES  OFF/ON mode; OFF silences and aborts the sequencer
- trigger  in  1  start request, level-sampled in IDLE
- melody_sel  in  2  melody table select, captured when trigger is accepted
- freq  out  8  note value to the oscillator; 0 when not playing a note
- playSound  out  1  one-cycle strobe at the start of each non-rest note
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a melody completes normally

Behaviour:
- Reset (nRst=1 at an edge): fsm=IDLE, index=0, tick=0, sel=0, freq=0, playSound=0, busy=0, done=0. Reset overrides everything, including mid-melody.
- All outputs are registered. tick is a 24-bit counter.
- FSM states: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE:
  - If trigger=1 and state==ON: capture sel=melody_sel, set index=0, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle): read entry = ROM[sel][index].
  - Entry 8'hFF (terminator): go to DONE.
  - Otherwise: go to PLAY, set tick=0, set freq=entry.
  - playSound=1 for the first PLAY cycle only, and only if entry != 0. Entry 0 is a rest: freq=0, no strobe.
- PLAY: tick increments each cycle. When tick==NOTE_TICKS-1: go to GAP, tick=0, freq=0.
- GAP: when tick==GAP_TICKS-1:
  - If index==MAX_NOTES-1: go to DONE (implicit end of table).
  - Otherwise: index+1, go to LOAD.
- DONE (1 cycle): done=1 for that cycle, then go to IDLE.
- Latency: trigger sampled at edge T gives freq/playSound valid in cycle T+2.
- Note period = 1 (LOAD) + NOTE_TICKS + GAP_TICKS cycles.
- trigger while busy: ignored; no queueing, no restart. A trigger held through DONE restarts only on the cycle after returning to IDLE.
- state==OFF in any non-IDLE state: next cycle fsm=IDLE, freq=0, playSound=0, done not asserted. trigger in IDLE with state==OFF is ignored.
- melody_sel changes while busy: ignored (captured copy is used).
- ROM contents (fixed):
  - melody 0 = {40,60,80,FF}
  - melody 1 = {120,0,120,FF}
  - melody 2 = {200,150,100,50,FF}
  - melody 3 = {FF}
  - Unlisted entries = FF.

Optional Feature:
- Macro MELODY_LOOP_EN.
- Defined: on reaching a terminator or the end of the table, if trigger==1 and state==ON, set index=0 and go to LOAD (seamless repeat, no done pulse). If trigger==0, go to DONE as normal.
- Undefined: every melody plays exactly once, then DONE.

Decomposition:
- Shared package holds:
  - MODE_TYPES (OFF=0, ON=1), the same typedef the oscillator consumes.
  - seq_state_t enum.
  - NOTE_END=8'hFF and NOTE_REST=8'h00.
  - Melody table constants.
- One natural sub-module: melody_rom, combinational, (sel, index) -> 8-bit entry.

Test Plan (NOTE_TICKS=4, GAP_TICKS=2):
- Reset held 2 cycles mid-PLAY of melody 0 -> next cycle freq=0, busy=0, playSound=0, done=0.
- state=ON, trigger pulse with sel=0 -> playSound pulses exactly 3 times, 7 cycles apart, with freq=40, 60, 80 for 4 cycles each and freq=0 in gaps; done pulses once; busy falls the cycle after done.
- sel=1 -> strobes only for both 120 notes (none for the rest); freq=0 for the full middle note slot.
- sel=3 -> no playSound; done asserted 2 cycles after trigger accept; busy high for exactly 2 cycles.
- Drop state to OFF during the second note of melody 2 -> fsm IDLE next cycle, freq=0, no done; re-trigger with ON -> starts at 200.
- Retrigger while busy is ignored (melody length unchanged). With MELODY_LOOP_EN and trigger held on sel=0 -> 40,60,80,40,... repeats with no done; releasing trigger -> done after the current pass.
